// File: rtl/imu_spi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : imu_spi_pkg
// Description : Shared types and constants for the IMU SPI reader: frame FSM
//               states, command-byte bit positions, frame lengths and a
//               helper that assembles the SPI command byte.
// Revision    : 1.0 - initial release
// ============================================================================
package imu_spi_pkg;

    // Frame-level states. The low/high halves of each bit are tracked by the
    // bit engine's sclk phase while the frame FSM sits in ST_SHIFT.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

    localparam int RW_BIT     = 7;
    localparam int MS_BIT     = 6;
    localparam int WRITE_BITS = 16;
    localparam int READ_BITS  = 40;
    localparam int RX_BYTES   = 4;
    localparam int BIT_CNT_W  = $clog2(READ_BITS + 1);

    // Command byte {RW, MS, ADDR[5:0]}, sent MSB first.
    function automatic logic [7:0] spi_cmd(input logic rw, input logic ms,
                                           input logic [5:0] addr);
        logic [7:0] cmd;
        cmd         = {2'b00, addr};
        cmd[RW_BIT] = rw;
        cmd[MS_BIT] = ms;
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imu_spi_reader_spi_bit_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_bit_engine
// Description : SPI mode-3 bit engine. Divides clk into sclk half-periods,
//               shifts the command/data word out MSB first on sclk falling,
//               samples sdo on sclk rising and counts bits down to the end
//               of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bit_engine
    import imu_spi_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic                   i_run,
    input  logic                   i_shift,
    input  logic [WRITE_BITS-1:0]  i_tx_word,
    input  logic [BIT_CNT_W-1:0]   i_num_bits,
    input  logic                   i_sdo,
    output logic                   o_tick,
    output logic                   o_bit_done,
    output logic                   o_frame_done,
    output logic                   o_sclk,
    output logic                   o_sdi,
    output logic [8*RX_BYTES-1:0]  o_rx_data
);

    localparam int                 c_div_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    logic [c_div_w-1:0]     r_div;
    logic                   r_high;
    logic [WRITE_BITS-1:0]  r_tx;
    logic [BIT_CNT_W-1:0]   r_bits;
    logic [8*RX_BYTES-1:0]  r_rx;
    logic                   w_rise;

    assign o_tick       = i_run && (r_div == c_div_last);
    assign w_rise       = i_shift && o_tick && !r_high;
    assign o_bit_done   = i_shift && o_tick && r_high;
    assign o_frame_done = o_bit_done && (r_bits == BIT_CNT_W'(1));
    assign o_sclk       = !(i_shift && !r_high);
    // Once the command (and write value) has shifted out, zeros follow, so
    // sdi is naturally 0 during the receive phase.
    assign o_sdi        = i_shift && r_tx[WRITE_BITS-1];
    assign o_rx_data    = r_rx;

    // Half-period divider: restarts at every phase boundary and while idle.
    always_ff @(posedge clk) begin
        if (reset || !i_run || o_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // sclk phase: low half first, toggling every half-period while shifting.
    always_ff @(posedge clk) begin
        if (reset || i_start) begin
            r_high <= 1'b0;
        end else if (i_shift && o_tick) begin
            r_high <= !r_high;
        end
    end

    // TX shift register and bit counter advance at the end of each bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx   <= '0;
            r_bits <= '0;
        end else if (i_start) begin
            r_tx   <= i_tx_word;
            r_bits <= i_num_bits;
        end else if (o_bit_done) begin
            r_tx   <= {r_tx[WRITE_BITS-2:0], 1'b0};
            r_bits <= r_bits - 1'b1;
        end
    end

    // RX shift register samples sdo on each sclk rising edge; after a read
    // frame it holds the last 32 bits, first byte in the top byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx <= '0;
        end else if (w_rise) begin
            r_rx <= {r_rx[8*RX_BYTES-2:0], i_sdo};
        end
    end

endmodule
`default_nettype wire

// File: rtl/imu_spi_reader.sv
`default_nettype none
// ============================================================================
// Module      : imu_spi_reader
// Description : SPI master for the accelerometer IMU. Writes the control
//               register once, then burst-reads X/Y acceleration words and
//               presents them as signed 16-bit samples with a valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module imu_spi_reader
    import imu_spi_pkg::*;
#(
    parameter int         CLK_DIV   = 1,
    parameter logic [5:0] CTRL_ADDR = 6'h20,
    parameter logic [7:0] CTRL_VAL  = 8'h57,
    parameter logic [5:0] DATA_ADDR = 6'h28,
    parameter int         POLL_GAP  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sdo,
    output logic        sdi,
    output logic        sclk,
    output logic        cs,
    output logic [15:0] x_data,
    output logic [15:0] y_data,
    output logic        data_valid,
    output logic        busy
);

    localparam logic [15:0] c_gap_last   = 16'(POLL_GAP - 1);
    localparam logic [WRITE_BITS-1:0] c_write_word =
        {spi_cmd(1'b0, 1'b0, CTRL_ADDR), CTRL_VAL};
    localparam logic [WRITE_BITS-1:0] c_read_word =
        {spi_cmd(1'b1, 1'b1, DATA_ADDR), 8'h00};

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_init_done;
    logic                   r_is_read;
    logic                   r_valid;
    logic [15:0]            r_x;
    logic [15:0]            r_y;
    logic [15:0]            r_gap;

    logic                   w_start;
    logic                   w_run;
    logic                   w_shift;
    logic                   w_tick;
    logic                   w_bit_done;
    logic                   w_frame_done;
    logic                   w_gap_end;
    logic                   w_hold_end;
    logic [WRITE_BITS-1:0]  w_tx_word;
    logic [BIT_CNT_W-1:0]   w_num_bits;
    logic [8*RX_BYTES-1:0]  w_rx;
    logic [7:0]             w_rx_byte [RX_BYTES];

    assign w_run      = (r_state == ST_CS_SETUP) || (r_state == ST_SHIFT) ||
                        (r_state == ST_CS_HOLD);
    assign w_shift    = (r_state == ST_SHIFT);
    assign w_gap_end  = (r_state == ST_GAP) && (r_gap == c_gap_last);
    assign w_hold_end = (r_state == ST_CS_HOLD) && w_tick;
    // The first frame after reset configures the IMU; every later one reads.
    assign w_tx_word  = r_init_done ? c_read_word : c_write_word;
    assign w_num_bits = r_init_done ? BIT_CNT_W'(READ_BITS) : BIT_CNT_W'(WRITE_BITS);

    assign cs         = !w_run;
    assign busy       = (r_state != ST_IDLE);
    assign x_data     = r_x;
    assign y_data     = r_y;
    assign data_valid = r_valid;

    // Byte 0 is the first byte received (XL) and sits at the top of w_rx.
    for (genvar gi = 0; gi < RX_BYTES; gi++) begin : g_rx_bytes
        assign w_rx_byte[gi] = w_rx[8*(RX_BYTES-1-gi) +: 8];
    end

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk          (clk),
        .reset        (reset),
        .i_start      (w_start),
        .i_run        (w_run),
        .i_shift      (w_shift),
        .i_tx_word    (w_tx_word),
        .i_num_bits   (w_num_bits),
        .i_sdo        (sdo),
        .o_tick       (w_tick),
        .o_bit_done   (w_bit_done),
        .o_frame_done (w_frame_done),
        .o_sclk       (sclk),
        .o_sdi        (sdi),
        .o_rx_data    (w_rx)
    );

    // Frame FSM next-state; enable is only looked at in IDLE and at GAP end.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next  = ST_CS_SETUP;
                    w_start = 1'b1;
                end
            end
            ST_CS_SETUP: begin
                if (w_tick) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_bit_done && w_frame_done) w_next = ST_CS_HOLD;
            end
            ST_CS_HOLD: begin
                if (w_tick) w_next = ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    if (enable) begin
                        w_next  = ST_CS_SETUP;
                        w_start = 1'b1;
                    end else begin
                        w_next  = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register, gap counter and frame-type latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_gap     <= '0;
            r_is_read <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gap   <= (r_state == ST_GAP) ? r_gap + 16'd1 : 16'd0;
            if (w_start) r_is_read <= r_init_done;
        end
    end

    // Init flag and sample outputs update as CS_HOLD ends; valid is a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_done <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_hold_end) begin
                if (r_is_read) begin
                    r_x     <= {w_rx_byte[1], w_rx_byte[0]};
                    r_y     <= {w_rx_byte[3], w_rx_byte[2]};
                    r_valid <= 1'b1;
                end else begin
                    r_init_done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imu_spi_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imu_spi_reader
// Description : Self-checking bench for imu_spi_reader. Two instances
//               (CLK_DIV=1/POLL_GAP=16 and CLK_DIV=3/POLL_GAP=5) are driven
//               by a behavioural IMU that answers read frames with chosen
//               bytes and records every frame seen on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imu_spi_reader;

    typedef struct {
        int          rises;
        int          cs_low;
        int          setup;
        int          tail;
        int          gap_before;
        int          nvalid;
        int          lo_min, lo_max, hi_min, hi_max;
        logic [39:0] tx;
        logic        valid_at_rise;
        logic [15:0] x, y;
    } frame_t;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [15:0] ex, ey;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, en0, rst1, en1;
    logic cs0, sclk0, sdi0, dv0, busy0, cs1, sclk1, sdi1, dv1, busy1;
    logic [15:0] x0, y0, x1, y1;
    logic        sdo_m [2];
    logic        cs_s [2], sclk_s [2], sdi_s [2], dv_s [2];
    logic [15:0] x_s [2], y_s [2];

    assign cs_s[0] = cs0;   assign cs_s[1] = cs1;
    assign sclk_s[0] = sclk0; assign sclk_s[1] = sclk1;
    assign sdi_s[0] = sdi0; assign sdi_s[1] = sdi1;
    assign dv_s[0] = dv0;   assign dv_s[1] = dv1;
    assign x_s[0] = x0;     assign x_s[1] = x1;
    assign y_s[0] = y0;     assign y_s[1] = y1;

    imu_spi_reader #(.CLK_DIV(1), .POLL_GAP(16)) u0 (
        .clk(clk), .reset(rst0), .enable(en0), .sdo(sdo_m[0]), .sdi(sdi0),
        .sclk(sclk0), .cs(cs0), .x_data(x0), .y_data(y0), .data_valid(dv0), .busy(busy0)
    );

    imu_spi_reader #(.CLK_DIV(3), .POLL_GAP(5)) u1 (
        .clk(clk), .reset(rst1), .enable(en1), .sdo(sdo_m[1]), .sdi(sdi1),
        .sclk(sclk1), .cs(cs1), .x_data(x1), .y_data(y1), .data_valid(dv1), .busy(busy1)
    );

    int         checks = 0;
    int         failures = 0;
    frame_t     cf [2];
    frame_t     q0 [$];
    frame_t     q1 [$];
    int         run [2] = '{0, 0};
    int         gapc [2] = '{0, 0};
    int         live_rises [2] = '{0, 0};
    int         stray [2] = '{0, 0};
    bit         first_fall [2] = '{1'b0, 1'b0};
    logic       pcs [2] = '{1'b1, 1'b1};
    logic       psclk [2] = '{1'b1, 1'b1};
    logic [7:0] resp [2][4];

    function automatic frame_t new_frame();
        frame_t f;
        f.rises = 0; f.cs_low = 0; f.setup = 0; f.tail = 0; f.gap_before = 0;
        f.nvalid = 0; f.lo_min = 1000000; f.lo_max = 0; f.hi_min = 1000000; f.hi_max = 0;
        f.tx = '0; f.valid_at_rise = 1'b0; f.x = '0; f.y = '0;
        return f;
    endfunction

    // Reference: first received byte is XL, then XH, YL, YH.
    function automatic logic [31:0] model_xy(input logic [7:0] b0, b1, b2, b3);
        return {b1, b0, b3, b2};
    endfunction

    // Behavioural IMU and bus monitor, sampled on the inactive clock edge.
    always @(negedge clk) begin : mon
        int         n;
        int         k;
        logic [7:0] bv;
        for (int d = 0; d < 2; d++) begin
            if (pcs[d] && !cs_s[d]) begin
                cf[d] = new_frame();
                cf[d].gap_before = gapc[d];
                run[d] = 0;
                first_fall[d] = 1'b1;
            end
            if (!cs_s[d]) begin
                cf[d].cs_low++;
                if (dv_s[d]) cf[d].nvalid++;
                if (sclk_s[d] != psclk[d]) begin
                    if (!sclk_s[d]) begin
                        if (first_fall[d]) begin
                            cf[d].setup = run[d];
                        end else begin
                            if (run[d] < cf[d].hi_min) cf[d].hi_min = run[d];
                            if (run[d] > cf[d].hi_max) cf[d].hi_max = run[d];
                        end
                        first_fall[d] = 1'b0;
                    end else begin
                        if (run[d] < cf[d].lo_min) cf[d].lo_min = run[d];
                        if (run[d] > cf[d].lo_max) cf[d].lo_max = run[d];
                        cf[d].rises++;
                        cf[d].tx = {cf[d].tx[38:0], sdi_s[d]};
                    end
                    run[d] = 1;
                end else begin
                    run[d]++;
                end
            end else if (!pcs[d]) begin
                cf[d].tail = run[d];
                cf[d].valid_at_rise = dv_s[d];
                if (dv_s[d]) cf[d].nvalid++;
                cf[d].x = x_s[d];
                cf[d].y = y_s[d];
                if (d == 0) q0.push_back(cf[d]);
                else        q1.push_back(cf[d]);
                gapc[d] = 1;
            end else begin
                gapc[d]++;
                if (dv_s[d]) stray[d]++;
            end
            if (cs_s[d] && (sdi_s[d] || !sclk_s[d])) stray[d]++;
            live_rises[d] = cf[d].rises;
            n = cf[d].rises;
            if (!cs_s[d] && n >= 8 && n < 40) begin
                k = n - 8;
                bv = resp[d][k / 8];
                sdo_m[d] = bv[7 - (k % 8)];
            end else begin
                sdo_m[d] = 1'b0;
            end
            pcs[d]   = cs_s[d];
            psclk[d] = sclk_s[d];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input int d, output frame_t f);
        bit got;
        got = 1'b0;
        f = new_frame();
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk); #1;
            if (d == 0 && q0.size() > 0) begin f = q0.pop_front(); got = 1'b1; end
            else if (d == 1 && q1.size() > 0) begin f = q1.pop_front(); got = 1'b1; end
        end
        chk("frame_arrived", got, 1);
    endtask

    task automatic wait_rises(input int d, input int n);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk); #1;
            if (!cs_s[d] && live_rises[d] >= n) got = 1'b1;
        end
        chk("bit_reached", got, 1);
    endtask

    task automatic set_resp(input int d, input vec_t v);
        resp[d][0] = v.b0; resp[d][1] = v.b1; resp[d][2] = v.b2; resp[d][3] = v.b3;
    endtask

    task automatic check_read(input frame_t f, input vec_t v, input int cs_low, input int gap);
        chk("read_cmd", f.tx[39:32], {2'b11, 6'h28});
        chk("read_sdi_zero", f.tx[31:0], 0);
        chk("read_rises", f.rises, 40);
        chk("read_cs_low", f.cs_low, cs_low);
        chk("read_gap_before", f.gap_before, gap);
        chk("read_valid_count", f.nvalid, 1);
        chk("valid_at_cs_rise", f.valid_at_rise, 1);
        chk("x_data", f.x, v.ex);
        chk("y_data", f.y, v.ey);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        vecs [5];
        vec_t        drop_v;
        frame_t      f;
        logic [31:0] m;

        rst0 = 1'b1; en0 = 1'b0; rst1 = 1'b1; en1 = 1'b0;
        vecs[0] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 16'h1234, 16'hABCD};
        vecs[1] = '{8'h01, 8'h00, 8'hFF, 8'h7F, 16'h0001, 16'h7FFF};
        for (int i = 2; i < 5; i++) begin
            vecs[i].b0 = 8'($urandom); vecs[i].b1 = 8'($urandom);
            vecs[i].b2 = 8'($urandom); vecs[i].b3 = 8'($urandom);
            m = model_xy(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
            vecs[i].ex = m[31:16];
            vecs[i].ey = m[15:0];
        end
        drop_v = '{8'h00, 8'h80, 8'hFF, 8'hFF, 16'h8000, 16'hFFFF};
        for (int d = 0; d < 2; d++) for (int b = 0; b < 4; b++) resp[d][b] = 8'h00;

        // Reset state
        repeat (5) @(negedge clk); #1;
        chk("rst_cs", cs0, 1);
        chk("rst_sclk", sclk0, 1);
        chk("rst_sdi", sdi0, 0);
        chk("rst_x", x0, 0);
        chk("rst_y", y0, 0);
        chk("rst_valid", dv0, 0);
        chk("rst_busy", busy0, 0);

        // Disabled: no bus activity
        rst0 = 1'b0;
        repeat (100) @(negedge clk); #1;
        chk("idle_no_frame", q0.size(), 0);
        chk("idle_cs_high", cs0, 1);
        chk("idle_stray", stray[0], 0);

        // Configuration write frame
        en0 = 1'b1;
        wait_frame(0, f);
        chk("write_rises", f.rises, 16);
        chk("write_addr", f.tx[15:8], 8'h20);
        chk("write_val", f.tx[7:0], 8'h57);
        chk("write_cs_low", f.cs_low, 34);
        chk("write_setup", f.setup, 1);
        chk("write_tail", f.tail, 2);
        chk("write_no_valid", f.nvalid, 0);

        // Read frames from the vector table
        for (int i = 0; i < 5; i++) begin
            set_resp(0, vecs[i]);
            wait_frame(0, f);
            check_read(f, vecs[i], 82, 16);
        end

        // Enable dropped mid-frame: frame completes, then IDLE
        set_resp(0, drop_v);
        wait_rises(0, 20);
        en0 = 1'b0;
        wait_frame(0, f);
        check_read(f, drop_v, 82, 16);
        repeat (150) @(negedge clk); #1;
        chk("drop_no_new_frame", q0.size(), 0);
        chk("drop_cs_idle", cs0, 1);
        chk("drop_busy", busy0, 0);
        chk("drop_x_hold", x0, 16'h8000);

        // Re-enable resumes reading; reset at bit 10 aborts the frame
        en0 = 1'b1;
        wait_rises(0, 10);
        chk("reenable_read_cmd", cf[0].tx[9:2], 8'hE8);
        rst0 = 1'b1;
        @(negedge clk); #1;
        chk("midrst_cs", cs0, 1);
        chk("midrst_sclk", sclk0, 1);
        chk("midrst_sdi", sdi0, 0);
        chk("midrst_x", x0, 0);
        chk("midrst_y", y0, 0);
        chk("midrst_valid", dv0, 0);
        chk("midrst_busy", busy0, 0);
        q0.delete();
        rst0 = 1'b0;
        wait_frame(0, f);
        chk("rewrite_rises", f.rises, 16);
        chk("rewrite_addr", f.tx[15:8], 8'h20);
        chk("rewrite_val", f.tx[7:0], 8'h57);

        // Slow instance: CLK_DIV=3, POLL_GAP=5
        rst1 = 1'b0;
        en1 = 1'b1;
        wait_frame(1, f);
        chk("u1_write_rises", f.rises, 16);
        chk("u1_write_cs_low", f.cs_low, 3 + 16 * 6 + 3);
        for (int i = 2; i < 4; i++) begin
            set_resp(1, vecs[i]);
            wait_frame(1, f);
            check_read(f, vecs[i], 3 + 40 * 6 + 3, 5);
            chk("u1_setup", f.setup, 3);
            chk("u1_tail", f.tail, 6);
            chk("u1_lo_min", f.lo_min, 3);
            chk("u1_lo_max", f.lo_max, 3);
            chk("u1_hi_min", f.hi_min, 3);
            chk("u1_hi_max", f.hi_max, 3);
        end

        chk("stray_u0", stray[0], 0);
        chk("stray_u1", stray[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
